// File: rtl/matrix_3x3_gen.sv
// 3x3 sliding-window generator: two line buffers plus three column shift registers.
// Define MATRIX_OUT_REG_EN to add an output register stage (latency 2 clk instead of 1).
module matrix_3x3_gen #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  output logic [DATA_W-1:0] data11,
  output logic [DATA_W-1:0] data12,
  output logic [DATA_W-1:0] data13,
  output logic [DATA_W-1:0] data21,
  output logic [DATA_W-1:0] data22,
  output logic [DATA_W-1:0] data23,
  output logic [DATA_W-1:0] data31,
  output logic [DATA_W-1:0] data32,
  output logic [DATA_W-1:0] data33,
  output logic              oen,
  output logic              frame_done
);

  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);

  logic [ColW-1:0]   col_q, col_d, col_cur;
  logic [RowW-1:0]   row_q, row_d, row_cur;
  logic [DATA_W-1:0] lb0_q [IMG_W];
  logic [DATA_W-1:0] lb1_q [IMG_W];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  // Window index k = 3*row + col, so 0 is data11 and 8 is data33.
  logic [DATA_W-1:0] win_q [9];
  logic [DATA_W-1:0] win_d [9];
  logic [DATA_W-1:0] win_o [9];
  logic              oen_q, oen_d;
  logic              done_q, done_d;
  logic              last_col, last_row;

  // frame_start overrides the position of the pixel accepted in the same cycle.
  always_comb begin
    col_cur  = frame_start ? '0 : col_q;
    row_cur  = frame_start ? '0 : row_q;
    last_col = (col_cur == ColW'(IMG_W - 1));
    last_row = (row_cur == RowW'(IMG_H - 1));
    col_d    = col_cur;
    row_d    = row_cur;
    if (pix_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
      end
    end
  end

  assign lb0_rd = lb0_q[col_cur];
  assign lb1_rd = lb1_q[col_cur];

  always_comb begin
    win_d  = win_q;
    oen_d  = 1'b0;
    done_d = 1'b0;
    if (pix_valid) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb0_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb1_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pix_in;
      oen_d    = (row_cur >= RowW'(2)) && (col_cur >= ColW'(2));
      done_d   = last_row && last_col;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      oen_q  <= 1'b0;
      done_q <= 1'b0;
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      oen_q  <= oen_d;
      done_q <= done_d;
      win_q  <= win_d;
    end
  end

  // Line buffers carry no reset; rows 0-1 of every frame refill them before any window is valid.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb0_q[col_cur] <= lb1_rd;
      lb1_q[col_cur] <= pix_in;
    end
  end

`ifdef MATRIX_OUT_REG_EN
  logic [DATA_W-1:0] out_q [9];
  logic              oen_out_q, done_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oen_out_q  <= 1'b0;
      done_out_q <= 1'b0;
      for (int k = 0; k < 9; k++) out_q[k] <= '0;
    end else begin
      oen_out_q  <= oen_q;
      done_out_q <= done_q;
      out_q      <= win_q;
    end
  end

  assign win_o      = out_q;
  assign oen        = oen_out_q;
  assign frame_done = done_out_q;
`else
  assign win_o      = win_q;
  assign oen        = oen_q;
  assign frame_done = done_q;
`endif

  assign data11 = win_o[0];
  assign data12 = win_o[1];
  assign data13 = win_o[2];
  assign data21 = win_o[3];
  assign data22 = win_o[4];
  assign data23 = win_o[5];
  assign data31 = win_o[6];
  assign data32 = win_o[7];
  assign data33 = win_o[8];

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Scoreboard bench for matrix_3x3_gen on a 4x4 image; expected windows queued at stimulus time.
module tb_matrix_3x3_gen;

  localparam int DW = 10;
  localparam int W  = 4;
  localparam int H  = 4;
`ifdef MATRIX_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef logic [8:0][DW-1:0] win_t;
  typedef struct {
    win_t d;
    logic done;
    int   cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_in = '0;
  logic [DW-1:0] data11, data12, data13, data21, data22, data23, data31, data32, data33;
  logic          oen, frame_done;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_oen = 0;
  bit   got_first = 0;
  win_t obs, first_win, last_win, hand_first;

  matrix_3x3_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .data11     (data11),
    .data12     (data12),
    .data13     (data13),
    .data21     (data21),
    .data22     (data22),
    .data23     (data23),
    .data31     (data31),
    .data32     (data32),
    .data33     (data33),
    .oen        (oen),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs = {data33, data32, data31, data23, data22, data21, data13, data12, data11};

  function automatic win_t model(input int base, input int r, input int c);
    win_t m;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        m[i*3+j] = DW'(base + (r - 2 + i) * 16 + (c - 2 + j));
    return m;
  endfunction

  task automatic chk(input string nm, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every oen pops one expected window and checks data, frame_done and timing.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && frame_done && !oen) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_without_oen: frame_done=1 oen=0 at cycle %0d", cyc);
    end
    if (rst_n && oen) begin
      n_oen++;
      if (!got_first) begin
        first_win = obs;
        got_first = 1;
      end
      last_win = obs;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_oen: got window %h at cycle %0d, expected none", obs, cyc);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e.d || frame_done !== e.done || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL window: got %h done=%b cyc=%0d, expected %h done=%b cyc=%0d",
                   obs, frame_done, cyc, e.d, e.done, e.cyc);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pix(input int base, input int r, input int c, input bit fs, input int gmax);
    exp_t e;
    if (gmax > 0) idle($urandom_range(gmax, 0));
    pix_in      = DW'(base + r * 16 + c);
    pix_valid   = 1'b1;
    frame_start = fs;
    if (r >= 2 && c >= 2) begin
      e.d    = model(base, r, c);
      e.done = (r == H - 1) && (c == W - 1);
      e.cyc  = cyc + LAT;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    pix_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic frame(input int base, input bit fs_first, input int gmax);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        pix(base, r, c, fs_first && r == 0 && c == 0, gmax);
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    idle(1);
    frame_start = 1'b0;
  endtask

  task automatic start_test();
    n_oen     = 0;
    got_first = 0;
  endtask

  task automatic drain(input string nm, input int exp_oen);
    idle(LAT + 3);
    chk({nm, "_queue_empty"}, (9 * DW)'(exp_q.size()), '0);
    chk({nm, "_oen_count"}, (9 * DW)'(n_oen), (9 * DW)'(exp_oen));
    exp_q.delete();
  endtask

  initial begin
    hand_first = {10'h022, 10'h021, 10'h020, 10'h012, 10'h011, 10'h010,
                  10'h002, 10'h001, 10'h000};

    // Test 1: reset state
    idle(3);
    rst_n = 1'b1;
    idle(3);
    chk("reset_window", obs, '0);
    chk("reset_oen", (9 * DW)'(oen), '0);
    chk("reset_frame_done", (9 * DW)'(frame_done), '0);

    // Test 2: back-to-back frame
    start_test();
    pulse_fs();
    frame(0, 0, 0);
    drain("t2", 4);
    chk("t2_first_window", first_win, hand_first);
    chk("t2_last_data33", (9 * DW)'(last_win[8]), (9 * DW)'(10'h033));
    chk("t2_last_data11", (9 * DW)'(last_win[0]), (9 * DW)'(10'h011));

    // Test 3: random gaps
    start_test();
    pulse_fs();
    frame(0, 0, 3);
    drain("t3", 4);

    // Test 4: abandon after (1,3), then fresh frame
    start_test();
    pulse_fs();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++)
        pix(10'h100, r, c, 1'b0, 0);
    pulse_fs();
    frame(0, 0, 1);
    drain("t4", 4);
    chk("t4_first_window", first_win, hand_first);

    // Test 5: two consecutive frames, second with frame_start on its first pixel
    start_test();
    pulse_fs();
    frame(0, 0, 0);
    frame(10'h080, 1, 0);
    drain("t5", 8);
    chk("t5_last_data11", (9 * DW)'(last_win[0]), (9 * DW)'(10'h091));

    // Test 6: reset at (2,1), then a full frame without frame_start
    start_test();
    pulse_fs();
    for (int k = 0; k < 2 * W + 2; k++) pix(10'h1c0, k / W, k % W, 1'b0, 0);
    rst_n = 1'b0;
    idle(2);
    chk("t6_reset_window", obs, '0);
    rst_n = 1'b1;
    idle(1);
    frame(0, 0, 2);
    drain("t6", 4);
    chk("t6_first_window", first_win, hand_first);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
